// File: rtl/decode_pkg.sv
// Shared types for the decode stage: operation classes, RV32I opcodes and
// the micro-op record that travels from decode into the issue skid buffer.
package decode_pkg;

  localparam int OP_W = 6;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 6'd0,
    OP_LUI   = 6'd1,
    OP_AUIPC = 6'd2,
    OP_JAL   = 6'd3,
    OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,
    OP_BNE   = 6'd6,
    OP_BLT   = 6'd7,
    OP_BGE   = 6'd8,
    OP_BLTU  = 6'd9,
    OP_BGEU  = 6'd10,
    OP_LB    = 6'd11,
    OP_LH    = 6'd12,
    OP_LW    = 6'd13,
    OP_LBU   = 6'd14,
    OP_LHU   = 6'd15,
    OP_SB    = 6'd16,
    OP_SH    = 6'd17,
    OP_SW    = 6'd18,
    OP_ADDI  = 6'd19,
    OP_SLTI  = 6'd20,
    OP_SLTIU = 6'd21,
    OP_XORI  = 6'd22,
    OP_ORI   = 6'd23,
    OP_ANDI  = 6'd24,
    OP_SLLI  = 6'd25,
    OP_SRLI  = 6'd26,
    OP_SRAI  = 6'd27,
    OP_ADD   = 6'd28,
    OP_SUB   = 6'd29,
    OP_SLL   = 6'd30,
    OP_SLT   = 6'd31,
    OP_SLTU  = 6'd32,
    OP_XOR   = 6'd33,
    OP_SRL   = 6'd34,
    OP_SRA   = 6'd35,
    OP_OR    = 6'd36,
    OP_AND   = 6'd37
  } op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic isBr;
    logic isLd;
    logic isSt;
    logic illegal;
  } flags_t;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_next;
    flags_t      flags;
  } uop_t;

endpackage

// File: rtl/decode_stage_rvc_expand.sv
// Expands a 16-bit RV32C instruction into its 32-bit RV32I equivalent.
// Unsupported or reserved encodings raise illegal_o and produce zero.
module rvc_expand
  import decode_pkg::*;
(
  input  logic [15:0] insHalf_i,
  output logic [31:0] insFull_o,
  output logic        illegal_o
);

  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] encB(input logic [12:0] off, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] encJ(input logic [20:0] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, OPC_JAL};
  endfunction

  function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  logic [15:0] h;
  logic [2:0]  f3;
  logic [4:0]  rdFull;
  logic [4:0]  rs2Full;
  logic [4:0]  primeLo;
  logic [4:0]  primeHi;
  logic [11:0] ciImm;
  logic [11:0] sp16Imm;
  logic [11:0] lwImm;
  logic [20:0] cjOff;
  logic [12:0] cbOff;

  assign h       = insHalf_i;
  assign f3      = h[15:13];
  assign rdFull  = h[11:7];
  assign rs2Full = h[6:2];
  assign primeLo = {2'b01, h[4:2]};
  assign primeHi = {2'b01, h[9:7]};
  assign ciImm   = {{6{h[12]}}, h[12], h[6:2]};
  assign sp16Imm = {{3{h[12]}}, h[4], h[3], h[5], h[2], h[6], 4'b0000};
  assign lwImm   = {5'b0, h[5], h[12:10], h[6], 2'b00};
  assign cjOff   = {{9{h[12]}}, h[12], h[8], h[10], h[9], h[6], h[7], h[2], h[11],
                    h[5], h[4], h[3], 1'b0};
  assign cbOff   = {{5{h[12]}}, h[6], h[5], h[2], h[11], h[10], h[4], h[3], 1'b0};

  // Quadrant / funct3 dispatch building the equivalent 32-bit encoding
  always_comb begin
    insFull_o = '0;
    illegal_o = 1'b0;
    case (h[1:0])
      2'b00: begin
        case (f3)
          3'b000: begin
            if (h[12:5] == 8'd0) illegal_o = 1'b1;
            else insFull_o = encI({2'b00, h[10:7], h[12:11], h[5], h[6], 2'b00},
                                  5'd2, 3'b000, primeLo, OPC_OPIMM);
          end
          3'b010:  insFull_o = encI(lwImm, primeHi, 3'b010, primeLo, OPC_LOAD);
          3'b110:  insFull_o = encS(lwImm, primeLo, primeHi, 3'b010);
          default: illegal_o = 1'b1;
        endcase
      end
      2'b01: begin
        case (f3)
          3'b000: insFull_o = encI(ciImm, rdFull, 3'b000, rdFull, OPC_OPIMM);
          3'b001: insFull_o = encJ(cjOff, 5'd1);
          3'b010: insFull_o = encI(ciImm, 5'd0, 3'b000, rdFull, OPC_OPIMM);
          3'b011: begin
            if ({h[12], h[6:2]} == 6'd0) illegal_o = 1'b1;
            else if (rdFull == 5'd2)
              insFull_o = encI(sp16Imm, 5'd2, 3'b000, 5'd2, OPC_OPIMM);
            else insFull_o = {{15{h[12]}}, h[6:2], rdFull, OPC_LUI};
          end
          3'b100: begin
            case (h[11:10])
              2'b00: begin
                if (h[12]) illegal_o = 1'b1;
                else insFull_o = encI({7'b0000000, h[6:2]}, primeHi, 3'b101, primeHi, OPC_OPIMM);
              end
              2'b01: begin
                if (h[12]) illegal_o = 1'b1;
                else insFull_o = encI({7'b0100000, h[6:2]}, primeHi, 3'b101, primeHi, OPC_OPIMM);
              end
              2'b10: insFull_o = encI(ciImm, primeHi, 3'b111, primeHi, OPC_OPIMM);
              default: begin
                if (h[12]) illegal_o = 1'b1;
                else begin
                  case (h[6:5])
                    2'b00:   insFull_o = encR(7'b0100000, primeLo, primeHi, 3'b000, primeHi);
                    2'b01:   insFull_o = encR(7'b0000000, primeLo, primeHi, 3'b100, primeHi);
                    2'b10:   insFull_o = encR(7'b0000000, primeLo, primeHi, 3'b110, primeHi);
                    default: insFull_o = encR(7'b0000000, primeLo, primeHi, 3'b111, primeHi);
                  endcase
                end
              end
            endcase
          end
          3'b101:  insFull_o = encJ(cjOff, 5'd0);
          3'b110:  insFull_o = encB(cbOff, 5'd0, primeHi, 3'b000);
          default: insFull_o = encB(cbOff, 5'd0, primeHi, 3'b001);
        endcase
      end
      2'b10: begin
        case (f3)
          3'b000: begin
            if (h[12]) illegal_o = 1'b1;
            else insFull_o = encI({7'b0000000, h[6:2]}, rdFull, 3'b001, rdFull, OPC_OPIMM);
          end
          3'b010: begin
            if (rdFull == 5'd0) illegal_o = 1'b1;
            else insFull_o = encI({4'b0, h[3], h[2], h[12], h[6], h[5], h[4], 2'b00},
                                  5'd2, 3'b010, rdFull, OPC_LOAD);
          end
          3'b100: begin
            if (!h[12]) begin
              if (rs2Full != 5'd0) insFull_o = encR(7'b0, rs2Full, 5'd0, 3'b000, rdFull);
              else if (rdFull == 5'd0) illegal_o = 1'b1;
              else insFull_o = encI(12'd0, rdFull, 3'b000, 5'd0, OPC_JALR);
            end else begin
              if (rs2Full != 5'd0) insFull_o = encR(7'b0, rs2Full, rdFull, 3'b000, rdFull);
              else if (rdFull == 5'd0) insFull_o = 32'h0010_0073;
              else insFull_o = encI(12'd0, rdFull, 3'b000, 5'd1, OPC_JALR);
            end
          end
          3'b110: insFull_o = encS({4'b0, h[8], h[7], h[12], h[11], h[10], h[9], 2'b00},
                                   rs2Full, 5'd2, 3'b010);
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: expands RVC, decodes RV32I into micro-ops and queues them in
// a small skid buffer so fetch can react to backpressure one cycle late.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int OP_WIDTH = 6
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                rdy_in,
  input  logic                clear,
  input  logic                from_if,
  input  logic [31:0]         from_if_ins,
  input  logic [31:0]         from_if_pc,
  input  logic [31:0]         from_if_pc_next,
  input  logic                from_issue_rdy,
  output logic                to_if_rdy,
  output logic                to_issue,
  output logic [OP_WIDTH-1:0] to_issue_op,
  output logic [4:0]          to_issue_rd,
  output logic [4:0]          to_issue_rs1,
  output logic [4:0]          to_issue_rs2,
  output logic [31:0]         to_issue_imm,
  output logic [31:0]         to_issue_pc,
  output logic [31:0]         to_issue_pc_next,
  output logic                to_issue_is_br,
  output logic                to_issue_is_ld,
  output logic                to_issue_is_st,
  output logic                to_issue_illegal,
  output logic                overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ROOM2_C = CNT_W'(DEPTH - 2);

  logic        isRvc;
  logic [31:0] expIns;
  logic        rvcIll;
  logic [31:0] ins;

  assign isRvc = (from_if_ins[1:0] != 2'b11);

  rvc_expand u_rvc (
    .insHalf_i (from_if_ins[15:0]),
    .insFull_o (expIns),
    .illegal_o (rvcIll)
  );

  assign ins = isRvc ? expIns : from_if_ins;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  fRd;
  logic [4:0]  fRs1;
  logic [4:0]  fRs2;
  logic [31:0] immI;
  logic [31:0] immS;
  logic [31:0] immB;
  logic [31:0] immU;
  logic [31:0] immJ;

  assign opc  = ins[6:0];
  assign fRd  = ins[11:7];
  assign f3   = ins[14:12];
  assign fRs1 = ins[19:15];
  assign fRs2 = ins[24:20];
  assign f7   = ins[31:25];
  assign immI = {{20{ins[31]}}, ins[31:20]};
  assign immS = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign immB = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  assign immU = {ins[31:12], 12'b0};
  assign immJ = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};

  op_e         decOp;
  logic [4:0]  decRd;
  logic [4:0]  decRs1;
  logic [4:0]  decRs2;
  logic [31:0] decImm;
  logic        decBr;
  logic        decLd;
  logic        decSt;
  logic        decIll;
  uop_t        decUop;

  // Common RV32I decode of the (possibly expanded) instruction into a micro-op
  always_comb begin
    decOp  = OP_NOP;
    decRd  = '0;
    decRs1 = '0;
    decRs2 = '0;
    decImm = '0;
    decBr  = 1'b0;
    decLd  = 1'b0;
    decSt  = 1'b0;
    decIll = 1'b0;
    case (opc)
      OPC_LUI:   begin decOp = OP_LUI;   decRd = fRd; decImm = immU; end
      OPC_AUIPC: begin decOp = OP_AUIPC; decRd = fRd; decImm = immU; end
      OPC_JAL:   begin decOp = OP_JAL;   decRd = fRd; decImm = immJ; decBr = 1'b1; end
      OPC_JALR: begin
        decOp = OP_JALR; decRd = fRd; decRs1 = fRs1; decImm = immI; decBr = 1'b1;
        if (f3 != 3'b000) decIll = 1'b1;
      end
      OPC_BRANCH: begin
        decRs1 = fRs1; decRs2 = fRs2; decImm = immB; decBr = 1'b1;
        case (f3)
          3'b000:  decOp = OP_BEQ;
          3'b001:  decOp = OP_BNE;
          3'b100:  decOp = OP_BLT;
          3'b101:  decOp = OP_BGE;
          3'b110:  decOp = OP_BLTU;
          3'b111:  decOp = OP_BGEU;
          default: decIll = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        decRd = fRd; decRs1 = fRs1; decImm = immI; decLd = 1'b1;
        case (f3)
          3'b000:  decOp = OP_LB;
          3'b001:  decOp = OP_LH;
          3'b010:  decOp = OP_LW;
          3'b100:  decOp = OP_LBU;
          3'b101:  decOp = OP_LHU;
          default: decIll = 1'b1;
        endcase
      end
      OPC_STORE: begin
        decRs1 = fRs1; decRs2 = fRs2; decImm = immS; decSt = 1'b1;
        case (f3)
          3'b000:  decOp = OP_SB;
          3'b001:  decOp = OP_SH;
          3'b010:  decOp = OP_SW;
          default: decIll = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        decRd = fRd; decRs1 = fRs1; decImm = immI;
        case (f3)
          3'b000: decOp = OP_ADDI;
          3'b010: decOp = OP_SLTI;
          3'b011: decOp = OP_SLTIU;
          3'b100: decOp = OP_XORI;
          3'b110: decOp = OP_ORI;
          3'b111: decOp = OP_ANDI;
          3'b001: begin
            decImm = {27'b0, fRs2};
            if (f7 == 7'b0000000) decOp = OP_SLLI;
            else decIll = 1'b1;
          end
          default: begin
            decImm = {27'b0, fRs2};
            if (f7 == 7'b0000000) decOp = OP_SRLI;
            else if (f7 == 7'b0100000) decOp = OP_SRAI;
            else decIll = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        decRd = fRd; decRs1 = fRs1; decRs2 = fRs2;
        case ({f7, f3})
          10'b0000000_000: decOp = OP_ADD;
          10'b0100000_000: decOp = OP_SUB;
          10'b0000000_001: decOp = OP_SLL;
          10'b0000000_010: decOp = OP_SLT;
          10'b0000000_011: decOp = OP_SLTU;
          10'b0000000_100: decOp = OP_XOR;
          10'b0000000_101: decOp = OP_SRL;
          10'b0100000_101: decOp = OP_SRA;
          10'b0000000_110: decOp = OP_OR;
          10'b0000000_111: decOp = OP_AND;
          default:         decIll = 1'b1;
        endcase
      end
      default: decIll = 1'b1;
    endcase
    if (isRvc && rvcIll) decIll = 1'b1;
    if (decIll) begin
      decOp  = OP_NOP;
      decRd  = '0;
      decRs1 = '0;
      decRs2 = '0;
      decImm = '0;
      decBr  = 1'b0;
      decLd  = 1'b0;
      decSt  = 1'b0;
    end
    decUop               = '0;
    decUop.op            = decOp;
    decUop.rd            = decRd;
    decUop.rs1           = decRs1;
    decUop.rs2           = decRs2;
    decUop.imm           = decImm;
    decUop.pc            = from_if_pc;
    decUop.pc_next       = from_if_pc_next;
    decUop.flags.isBr    = decBr;
    decUop.flags.isLd    = decLd;
    decUop.flags.isSt    = decSt;
    decUop.flags.illegal = decIll;
  end

  uop_t             mem_q [DEPTH];
  uop_t             out_q;
  uop_t             out_d;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] head_d;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] remain;
  logic             overflow_q;
  logic             enq;
  logic             deq;

  assign enq = from_if && (count_q < FULL_C);
  assign deq = (count_q != '0) && from_issue_rdy;

  // Next head pointer/count and the micro-op that will sit at the head next cycle
  always_comb begin
    head_d  = deq ? head_q + PTR_W'(1) : head_q;
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    remain  = count_q - CNT_W'(deq);
    out_d   = out_q;
    if (count_d != '0) begin
      if (remain != '0) out_d = mem_q[head_d];
      else out_d = decUop;
    end
  end

  // Buffer storage, pointers, head copy and sticky overflow flag
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      out_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (rdy_in) begin
      if (clear) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (enq) begin
          mem_q[tail_q] <= decUop;
          tail_q        <= tail_q + PTR_W'(1);
        end
        if (from_if && (count_q == FULL_C)) overflow_q <= 1'b1;
        head_q  <= head_d;
        count_q <= count_d;
        out_q   <= out_d;
      end
    end
  end

  assign to_if_rdy        = (count_q <= ROOM2_C);
  assign to_issue         = (count_q != '0);
  assign to_issue_op      = OP_WIDTH'(out_q.op);
  assign to_issue_rd      = out_q.rd;
  assign to_issue_rs1     = out_q.rs1;
  assign to_issue_rs2     = out_q.rs2;
  assign to_issue_imm     = out_q.imm;
  assign to_issue_pc      = out_q.pc;
  assign to_issue_pc_next = out_q.pc_next;
  assign to_issue_is_br   = out_q.flags.isBr;
  assign to_issue_is_ld   = out_q.flags.isLd;
  assign to_issue_is_st   = out_q.flags.isSt;
  assign to_issue_illegal = out_q.flags.illegal;
  assign overflow_err     = overflow_q;

endmodule
